// File: rtl/ram_pkg.sv
// Shared types and helpers for the synchronous-read dual-port RAM family.
package ram_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  function automatic int lane_count(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Extra register stages behind the first read register; each stage holds its
// data while its valid bit is low, so q keeps its last value between reads.
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  q_valid,
  output logic [DATA_WIDTH-1:0] q
);

  logic                  v_chain [STAGES+1];
  logic [DATA_WIDTH-1:0] d_chain [STAGES+1];

  assign v_chain[0] = in_valid;
  assign d_chain[0] = in_data;

  for (genvar i = 1; i <= STAGES; i++) begin : g_stage
    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_d, data_q;

    always_comb begin
      valid_d = v_chain[i-1];
      data_d  = v_chain[i-1] ? d_chain[i-1] : data_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign v_chain[i] = valid_q;
    assign d_chain[i] = data_q;
  end

  assign q_valid = v_chain[STAGES];
  assign q       = d_chain[STAGES];

endmodule

// File: rtl/dp_ram_sync_clr.sv
// Single-clock dual-port RAM: byte-enabled write port, pipelined synchronous
// read port with write-first forwarding, and a clear engine that sweeps all words.
module dp_ram_sync_clr
  import ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    ADDR_WIDTH   = 6,
  parameter int                    BYTE_WIDTH   = 8,
  parameter int                    RD_LATENCY   = 1,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE    = '0,
  parameter bit                    CLR_ON_RESET = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wren,
  input  logic [ADDR_WIDTH-1:0]            wraddress,
  input  logic [DATA_WIDTH-1:0]            data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteena,
  input  logic                             rden,
  input  logic [ADDR_WIDTH-1:0]            rdaddress,
  output logic [DATA_WIDTH-1:0]            q,
  output logic                             q_valid,
  input  logic                             clr_req,
  output logic                             clr_busy
);

  localparam int LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("dp_ram_sync_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("dp_ram_sync_clr: RD_LATENCY must be 1, 2 or 3");
  end

  clr_state_e            state_d, state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_d, clr_cnt_q;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d   = CLR_RUN;
          clr_cnt_d = '0;
        end
      end
      CLR_RUN: begin
        if (clr_req) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == '1) begin
          state_d   = CLR_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLR_ON_RESET ? CLR_RUN : CLR_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign clr_busy = (state_q == CLR_RUN);

  // The clear engine owns the write port while busy; user writes are dropped.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [LANES-1:0]      mem_be;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wraddress;
    mem_wdata = data;
    mem_be    = byteena;
    if (!rst) begin
      if (clr_busy) begin
        mem_we    = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wdata = CLR_VALUE;
        mem_be    = '1;
      end else begin
        mem_we = wren;
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; contents are only changed by writes and clear sweeps.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_be[i]) mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Write-first: lanes written at this edge to the read address are forwarded.
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;
  logic                  rd_valid_d, rd_valid_q;

  always_comb begin
    rd_word = mem[rdaddress];
    if (clr_busy) begin
      rd_word = CLR_VALUE;
    end else if (wren && (wraddress == rdaddress)) begin
      for (int i = 0; i < LANES; i++) begin
        if (byteena[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    rd_valid_d = rden;
    rd_data_d  = rden ? rd_word : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  if (RD_LATENCY > 1) begin : g_pipe
    ram_rd_pipe #(
      .DATA_WIDTH(DATA_WIDTH),
      .STAGES    (RD_LATENCY - 1)
    ) u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_valid(rd_valid_q),
      .in_data (rd_data_q),
      .q_valid (q_valid),
      .q       (q)
    );
  end else begin : g_direct
    assign q_valid = rd_valid_q;
    assign q       = rd_data_q;
  end

endmodule

// File: tb/tb_dp_ram_sync_clr.sv
// Directed bench: three RAM instances share one stimulus stream and differ in
// read latency and clear value; every expected value is hand-computed.
module tb_dp_ram_sync_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        wren, rden, clr_req;
  logic [3:0]  wraddress, rdaddress;
  logic [15:0] data;
  logic [1:0]  byteena;

  logic [15:0] q_a, q_b, q_c;
  logic        qv_a, qv_b, qv_c;
  logic        busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: latency 1, clear to 0; b: latency 3, clear to 0; c: latency 1, clear to 5A5A
  dp_ram_sync_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RD_LATENCY(1),
                    .CLR_VALUE(16'h0000), .CLR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst(rst), .wren(wren), .wraddress(wraddress), .data(data),
    .byteena(byteena), .rden(rden), .rdaddress(rdaddress), .q(q_a), .q_valid(qv_a),
    .clr_req(clr_req), .clr_busy(busy_a));

  dp_ram_sync_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RD_LATENCY(3),
                    .CLR_VALUE(16'h0000), .CLR_ON_RESET(1'b1)) u_b (
    .clk(clk), .rst(rst), .wren(wren), .wraddress(wraddress), .data(data),
    .byteena(byteena), .rden(rden), .rdaddress(rdaddress), .q(q_b), .q_valid(qv_b),
    .clr_req(clr_req), .clr_busy(busy_b));

  dp_ram_sync_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .RD_LATENCY(1),
                    .CLR_VALUE(16'h5A5A), .CLR_ON_RESET(1'b1)) u_c (
    .clk(clk), .rst(rst), .wren(wren), .wraddress(wraddress), .data(data),
    .byteena(byteena), .rden(rden), .rdaddress(rdaddress), .q(q_c), .q_valid(qv_c),
    .clr_req(clr_req), .clr_busy(busy_c));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Counts sampled cycles with clr_busy high; optionally pulses clr_req after
  // restart_at counted cycles. Also flags any q_valid pulse on instance b.
  task automatic count_busy(input int restart_at, output int n, output logic saw_qv_b);
    n = 0;
    saw_qv_b = 1'b0;
    while (busy_a && n < 60) begin
      clr_req = (n == restart_at);
      n++;
      step();
      clr_req = 1'b0;
      if (qv_b) saw_qv_b = 1'b1;
    end
  endtask

  int   n;
  logic saw;

  initial begin
    rst = 1'b1; wren = 1'b0; rden = 1'b0; clr_req = 1'b0;
    wraddress = '0; rdaddress = '0; data = '0; byteena = '0;
    @(negedge clk);
    step();
    step();
    check("reset_q", q_a, 16'h0000);
    check("reset_q_valid", {15'd0, qv_a}, 16'h0000);
    check("reset_busy_held", {15'd0, busy_a}, 16'h0001);

    // Reset sweep: exactly 16 busy cycles after release.
    rst = 1'b0;
    count_busy(-1, n, saw);
    check("reset_sweep_len", 16'(n), 16'd16);

    for (int i = 0; i < 16; i++) begin
      rden = 1'b1; rdaddress = 4'(i);
      step();
      check($sformatf("sweep_rd_q_%0d", i), q_a, 16'h0000);
      check($sformatf("sweep_rd_qv_%0d", i), {15'd0, qv_a}, 16'h0001);
    end
    check("sweep_rd_c_q15", q_c, 16'h5A5A);
    rden = 1'b0;
    step();
    check("rd_qv_drop", {15'd0, qv_a}, 16'h0000);
    check("rd_q_hold", q_c, 16'h5A5A);

    // Byte enables.
    wren = 1'b1; wraddress = 4'd3; data = 16'hABCD; byteena = 2'b11;
    step();
    data = 16'h1234; byteena = 2'b01;
    step();
    wren = 1'b0; rden = 1'b1; rdaddress = 4'd3;
    step();
    check("byteena_a", q_a, 16'hAB34);
    check("byteena_c", q_c, 16'hAB34);

    // byteena=0 write is a no-op.
    rden = 1'b0; wren = 1'b1; data = 16'hFFFF; byteena = 2'b00;
    step();
    wren = 1'b0; rden = 1'b1;
    step();
    check("byteena_zero", q_a, 16'hAB34);

    // Same-edge read/write forwarding.
    rden = 1'b0; wren = 1'b1; wraddress = 4'd5; data = 16'h00FF; byteena = 2'b11;
    step();
    data = 16'hEE11; byteena = 2'b10; rden = 1'b1; rdaddress = 4'd5;
    step();
    check("fwd_q", q_a, 16'hEEFF);
    check("fwd_qv", {15'd0, qv_a}, 16'h0001);
    wren = 1'b0;
    step();
    check("fwd_stored", q_a, 16'hEEFF);

    // Latency-3 back-to-back reads on instance b.
    rden = 1'b0; wren = 1'b1; byteena = 2'b11;
    for (int i = 0; i < 3; i++) begin
      wraddress = 4'(i); data = 16'(i + 1);
      step();
    end
    wren = 1'b0;
    step();
    step();
    step();
    rden = 1'b1; rdaddress = 4'd0;
    step();
    check("lat3_qv_n", {15'd0, qv_b}, 16'h0000);
    rdaddress = 4'd1;
    step();
    check("lat3_qv_n1", {15'd0, qv_b}, 16'h0000);
    rdaddress = 4'd2;
    step();
    check("lat3_qv_n2", {15'd0, qv_b}, 16'h0001);
    check("lat3_q_n2", q_b, 16'h0001);
    rden = 1'b0;
    step();
    check("lat3_qv_n3", {15'd0, qv_b}, 16'h0001);
    check("lat3_q_n3", q_b, 16'h0002);
    step();
    check("lat3_qv_n4", {15'd0, qv_b}, 16'h0001);
    check("lat3_q_n4", q_b, 16'h0003);
    step();
    check("lat3_qv_n5", {15'd0, qv_b}, 16'h0000);
    check("lat3_q_hold", q_b, 16'h0003);

    // Clear on request with a dropped user write and a read during the sweep.
    wren = 1'b1; byteena = 2'b11; wraddress = 4'd9; data = 16'h1234;
    step();
    wraddress = 4'd7; data = 16'h7777;
    step();
    wren = 1'b0; clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("clr_req_busy", {15'd0, busy_c}, 16'h0001);
    wren = 1'b1; wraddress = 4'd7; data = 16'h1111; rden = 1'b1; rdaddress = 4'd9;
    step();
    wren = 1'b0; rden = 1'b0;
    check("clr_rd_c", q_c, 16'h5A5A);
    check("clr_rd_c_qv", {15'd0, qv_c}, 16'h0001);
    check("clr_rd_a", q_a, 16'h0000);
    n = 0;
    while (busy_c && n < 40) begin
      n++;
      step();
    end
    check("clr_busy_fall", {15'd0, busy_c}, 16'h0000);
    rden = 1'b1; rdaddress = 4'd7;
    step();
    rden = 1'b0;
    check("clr_drop_c", q_c, 16'h5A5A);
    check("clr_drop_a", q_a, 16'h0000);

    // Restart by clr_req after 8 sweep cycles: 24 busy cycles in total.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    count_busy(7, n, saw);
    check("restart_len", 16'(n), 16'd24);

    // Reset after 10 sweep cycles: outputs cleared, fresh 16-cycle sweep.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin
        rden = 1'b1; rdaddress = 4'd2;
      end
      step();
    end
    check("pre_rst_c_q", q_c, 16'h5A5A);
    rden = 1'b0; rst = 1'b1;
    step();
    check("mid_rst_q_a", q_a, 16'h0000);
    check("mid_rst_qv_a", {15'd0, qv_a}, 16'h0000);
    check("mid_rst_q_c", q_c, 16'h0000);
    check("mid_rst_qv_b", {15'd0, qv_b}, 16'h0000);
    check("mid_rst_busy", {15'd0, busy_a}, 16'h0001);
    step();
    rst = 1'b0;
    count_busy(-1, n, saw);
    check("rst_sweep_len", 16'(n), 16'd16);
    check("rst_flush_b", {15'd0, saw}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_ram_sync_clr.md
Name: dp_ram_sync_clr

Overview:
- Parametrised single-clock dual-port RAM: one write port and one read port.
- Successor to the team's asynchronous-read dual-port RAM, adding:
  - synchronous read with a selectable pipeline latency (1-3)
  - per-byte write enables
  - write-first read-during-write forwarding
  - a hardware clear engine that sweeps every word to a constant after reset or on request
- Used for line buffers, intra-prediction neighbour storage and per-CTB parameter tables in the decoder, where a table must be zeroed between pictures.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 6, address width; depth = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per byte-enable lane.
- RD_LATENCY, 1, cycles from rden to q; legal values 1, 2, 3.
- CLR_VALUE, 0, DATA_WIDTH-bit constant written by the clear engine.
- CLR_ON_RESET, 1, 1 = start a clear sweep automatically when rst deasserts.

Ports:
- clk  in  1  single clock for both ports.
- rst  in  1  synchronous, active-high reset.
- wren  in  1  write strobe.
- wraddress  in  ADDR_WIDTH  write address.
- data  in  DATA_WIDTH  write data.
- byteena  in  DATA_WIDTH/BYTE_WIDTH  per-lane write enable; lane i covers data[i*BYTE_WIDTH +: BYTE_WIDTH].
- rden  in  1  read strobe.
- rdaddress  in  ADDR_WIDTH  read address.
- q  out  DATA_WIDTH  read data.
- q_valid  out  1  one-cycle pulse, RD_LATENCY cycles after an accepted rden.
- clr_req  in  1  one-cycle pulse to start a clear sweep.
- clr_busy  out  1  high while the clear engine owns the write port.

Behaviour:
- Reset (rst high at a clk edge):
  - q=0, q_valid=0, read pipeline flushed.
  - Clear counter set to 0.
  - State = CLEAR if CLR_ON_RESET=1, else IDLE; clr_busy follows state, including while rst is held.
  - RAM contents are not touched by rst itself.
- Clear FSM, two states:
  - IDLE -> CLEAR on clr_req; counter set to 0.
  - CLEAR: each cycle, RAM[counter] <= CLR_VALUE (all lanes) and counter increments.
  - CLEAR -> IDLE on the cycle counter = 2**ADDR_WIDTH-1 is written. A sweep is exactly 2**ADDR_WIDTH cycles; clr_busy falls the cycle after the last word is written.
  - clr_req while in CLEAR restarts the counter at 0 (sweep lengthens).
  - rst mid-sweep behaves as reset above; with CLR_ON_RESET=1 the sweep restarts from 0.
- Writes in IDLE:
  - At the clk edge with wren=1, lanes with byteena[i]=1 are updated; other lanes hold.
  - byteena=0 with wren=1 is a no-op.
  - In CLEAR, user wren is ignored and dropped, not queued.
- Reads:
  - rden sampled at edge N; q and q_valid=1 present after edge N+RD_LATENCY-1.
  - RD_LATENCY=1 means q is valid the cycle after rden.
  - Back-to-back rden gives one result per cycle, in order.
  - q holds its last value when q_valid=0.
- Read-during-write, same address, same edge (IDLE): write-first. q returns the merged word: new data on enabled lanes, old RAM contents on the rest.
- Read while clr_busy=1: accepted, q_valid pulses normally, q = CLR_VALUE regardless of address or sweep progress.
- A read issued the cycle clr_busy falls returns true RAM contents.
- Address widths are exact; there is no out-of-range case.
- Parameter checks: an elaboration-time error if DATA_WIDTH % BYTE_WIDTH != 0 or RD_LATENCY is not 1-3.

Decomposition:
- Shared package ram_pkg:
  - clear-FSM state enum (CLR_IDLE, CLR_RUN)
  - function for the byte-lane count
  - legal RD_LATENCY bounds
- One sub-module, ram_rd_pipe: RD_LATENCY-1 extra register stages for q/q_valid with synchronous reset of the valid bits.
- Storage array, write-merge, forwarding and clear FSM stay in the top module.

Test Plan (DATA_WIDTH=16, ADDR_WIDTH=4, BYTE_WIDTH=8, CLR_VALUE=16'h0000 unless stated):
- Reset sweep, CLR_ON_RESET=1: release rst -> clr_busy high for exactly 16 cycles. Then rden rdaddress=0..15 -> every q=16'h0000, q_valid one cycle later each.
- Byte enables: write 16'hABCD to addr 3 with byteena=2'b11, then 16'h1234 with byteena=2'b01, read addr 3 -> q=16'hAB34.
- Same-edge read/write: addr 5 holds 16'h00FF; at one edge wren=1, data=16'hEE11, byteena=2'b10, rden=1, both addresses 5 -> q=16'hEEFF next cycle.
- RD_LATENCY=3 back-to-back: addrs 0,1,2 hold 16'h0001, 16'h0002, 16'h0003; rden on three consecutive cycles -> q_valid high on edges N+2..N+4 with q=16'h0001, 16'h0002, 16'h0003; q_valid low afterwards, q holds 16'h0003.
- Clear on request, CLR_VALUE=16'h5A5A: clr_req while IDLE, wren to addr 7 during the sweep, read addr 9 during the sweep.
  - Read returns 16'h5A5A.
  - After clr_busy falls, addr 7 reads 16'h5A5A (user write dropped).
- Restart and mid-sweep reset: clr_req at sweep cycle 8 -> clr_busy stays high 8+16=24 cycles total. Separately, rst at sweep cycle 10 with CLR_ON_RESET=1 -> a fresh 16-cycle sweep follows, q=0 and q_valid=0 during reset.
